// File: rtl/bomb_game_if.sv
// bomb_game_if -- signal bundle between the bomb game sequencer and its
// peers (start button, score block, display logic).
//
// Signal names are written from the sequencer's point of view:
//   i_Start     start/acknowledge pulse (debounced, one cycle)
//   i_Pause     pause toggle pulse (only when BOMB_PAUSE_EN is defined)
//   i_Score     current 5-bit score from the score block
//   o_State     game state code
//   o_Sec1Tick  one-cycle pulse per second while the game runs
//   o_ScoreClr  one-cycle pulse telling the score block to zero its score
//   o_TimeLeft  remaining seconds
//   o_Time10    tens digit of o_TimeLeft
//   o_Time1     ones digit of o_TimeLeft
//
// Modports: slave = the sequencer, master = the environment driving it.
// Optional feature macro: BOMB_PAUSE_EN (adds i_Pause).
interface bomb_game_if;
  logic       i_Start;
`ifdef BOMB_PAUSE_EN
  logic       i_Pause;
`endif
  logic [4:0] i_Score;
  logic [2:0] o_State;
  logic       o_Sec1Tick;
  logic       o_ScoreClr;
  logic [5:0] o_TimeLeft;
  logic [3:0] o_Time10;
  logic [3:0] o_Time1;

`ifdef BOMB_PAUSE_EN
  modport slave  (input  i_Start, i_Pause, i_Score,
                  output o_State, o_Sec1Tick, o_ScoreClr, o_TimeLeft, o_Time10, o_Time1);
  modport master (output i_Start, i_Pause, i_Score,
                  input  o_State, o_Sec1Tick, o_ScoreClr, o_TimeLeft, o_Time10, o_Time1);
`else
  modport slave  (input  i_Start, i_Score,
                  output o_State, o_Sec1Tick, o_ScoreClr, o_TimeLeft, o_Time10, o_Time1);
  modport master (output i_Start, i_Score,
                  input  o_State, o_Sec1Tick, o_ScoreClr, o_TimeLeft, o_Time10, o_Time1);
`endif
endinterface

// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl -- top-level sequencer for the bomb game.
// Owns the game FSM, the 1-second tick divider, the countdown timer and the
// score-clear pulse. Reads the score block's score to detect a cleared bomb.
//
// Ports:
//   i_Clk    system clock
//   i_Rst    synchronous, active-high reset
//   io_Game  bomb_game_if.slave (start/pause/score in; state, tick,
//            score-clear, time-left and BCD digits out)
//
// Optional feature macro: BOMB_PAUSE_EN -- adds a pause toggle that freezes
// the divider while the game runs.
//
// state        | meaning
// S_IDLE  000  | waiting for start, timer held at GAME_SEC
// S_START 001  | game running, divider and countdown active
// S_CLEAR 010  | score reached target, timer frozen
// S_FAIL  011  | countdown expired, timer frozen
module bomb_game_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SEC     = 30,
  parameter int TARGET_SCORE = 20
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  bomb_game_if.slave  io_Game
);

  localparam int              DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_HZ - 1);
  localparam logic [5:0]      TIME_INIT = 6'(GAME_SEC);
  localparam logic [4:0]      TARGET    = 5'(TARGET_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_START = 3'b001,
    S_CLEAR = 3'b010,
    S_FAIL  = 3'b011
  } state_t;

  state_t           r_State;
  state_t           w_NextState;
  logic [DIV_W-1:0] r_Div;
  logic [5:0]       r_TimeLeft;
  logic             r_Sec1Tick;
  logic             r_ScoreClr;
  logic             w_ScoreClr;
  logic             w_Run;
  logic             w_Tc;

`ifdef BOMB_PAUSE_EN
  logic r_Paused;
`endif

  always_comb begin
    w_NextState = r_State;
    w_ScoreClr  = 1'b0;
    w_Run       = 1'b0;
    case (r_State)
      S_IDLE: begin
        if (io_Game.i_Start) begin
          w_NextState = S_START;
          w_ScoreClr  = 1'b1;
        end
      end
      S_START: begin
`ifdef BOMB_PAUSE_EN
        w_Run = !r_Paused;
`else
        w_Run = 1'b1;
`endif
        // Clear has priority: a final tick landing with the winning score
        // still counts as a clear.
        if (io_Game.i_Score >= TARGET)
          w_NextState = S_CLEAR;
        else if (r_TimeLeft == 6'd0)
          w_NextState = S_FAIL;
      end
      S_CLEAR, S_FAIL: begin
        if (io_Game.i_Start)
          w_NextState = S_IDLE;
      end
      default: w_NextState = S_IDLE;
    endcase
  end

  assign w_Tc = w_Run && (r_Div == DIV_TC);

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      r_State <= S_IDLE;
    else
      r_State <= w_NextState;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Div      <= '0;
      r_TimeLeft <= TIME_INIT;
      r_Sec1Tick <= 1'b0;
      r_ScoreClr <= 1'b0;
    end else begin
      r_Sec1Tick <= w_Tc;
      r_ScoreClr <= w_ScoreClr;
      case (r_State)
        S_START: begin
          if (w_Run)
            r_Div <= w_Tc ? '0 : r_Div + 1'b1;
          if (w_Tc && (r_TimeLeft != 6'd0))
            r_TimeLeft <= r_TimeLeft - 6'd1;
        end
        S_CLEAR, S_FAIL: begin
          if (io_Game.i_Start)
            r_TimeLeft <= TIME_INIT;
        end
        default: begin
          r_Div      <= '0;
          r_TimeLeft <= TIME_INIT;
        end
      endcase
    end
  end

`ifdef BOMB_PAUSE_EN
  // Toggle only while the game keeps running; any exit drops the flag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      r_Paused <= 1'b0;
    else if ((r_State == S_START) && (w_NextState == S_START)) begin
      if (io_Game.i_Pause)
        r_Paused <= !r_Paused;
    end else
      r_Paused <= 1'b0;
  end
`endif

  assign io_Game.o_State    = r_State;
  assign io_Game.o_Sec1Tick = r_Sec1Tick;
  assign io_Game.o_ScoreClr = r_ScoreClr;
  assign io_Game.o_TimeLeft = r_TimeLeft;
  assign io_Game.o_Time10   = 4'(r_TimeLeft / 6'd10);
  assign io_Game.o_Time1    = 4'(r_TimeLeft - 6'(io_Game.o_Time10) * 6'd10);

endmodule

// File: tb/tb_bomb_game_ctrl.sv
module tb_bomb_game_ctrl;

  localparam int CLK_HZ       = 10;
  localparam int GAME_SEC     = 3;
  localparam int TARGET_SCORE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  bomb_game_if bus ();

  bomb_game_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .GAME_SEC    (GAME_SEC),
    .TARGET_SCORE(TARGET_SCORE)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .io_Game(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] st;
    logic [5:0] tl;
    logic [3:0] t10;
    logic [3:0] t1;
    logic       tick;
    logic       clr;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks  = 0;
  int         n_err     = 0;
  logic       force_chk = 1'b0;
  logic       mon_en    = 1'b0;
  logic       done      = 1'b0;
  logic [2:0] prev_state = 3'b000;

  function automatic void expect_ev(string name, int c, logic [2:0] st, logic [5:0] tl,
                                    logic tick, logic clr);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.st   = st;
    e.tl   = tl;
    e.t10  = 4'(tl / 10);
    e.t1   = 4'(tl % 10);
    e.tick = tick;
    e.clr  = clr;
    exp_q.push_back(e);
  endfunction

  // Monitor: any tick, score-clear or state change (or a forced snapshot)
  // is an output event and is matched against the next expected record.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL pending_events: %0d expected events never seen, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
    end else if (mon_en) begin
      if (force_chk || bus.o_Sec1Tick === 1'b1 || bus.o_ScoreClr === 1'b1 ||
          bus.o_State !== prev_state) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event cyc=%0d got st=%0d tl=%0d tick=%0b clr=%0b, want no event",
                   cyc, bus.o_State, bus.o_TimeLeft, bus.o_Sec1Tick, bus.o_ScoreClr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || bus.o_State !== e.st || bus.o_TimeLeft !== e.tl ||
              bus.o_Time10 !== e.t10 || bus.o_Time1 !== e.t1 ||
              bus.o_Sec1Tick !== e.tick || bus.o_ScoreClr !== e.clr) begin
            n_err++;
            $display("FAIL %s got cyc=%0d st=%0d tl=%0d t10=%0d t1=%0d tick=%0b clr=%0b, want cyc=%0d st=%0d tl=%0d t10=%0d t1=%0d tick=%0b clr=%0b",
                     e.name, cyc, bus.o_State, bus.o_TimeLeft, bus.o_Time10, bus.o_Time1,
                     bus.o_Sec1Tick, bus.o_ScoreClr,
                     e.cyc, e.st, e.tl, e.t10, e.t1, e.tick, e.clr);
          end
        end
      end
      prev_state = bus.o_State;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(int n);
    while (cyc < n) step();
  endtask

  task automatic snap(string name, logic [2:0] st, logic [5:0] tl);
    expect_ev(name, cyc, st, tl, 1'b0, 1'b0);
    force_chk = 1'b1;
    step();
    force_chk = 1'b0;
  endtask

  task automatic start_game(string name, output int t0);
    bus.i_Start = 1'b1;
    t0 = cyc + 1;
    expect_ev(name, t0, 3'b001, 6'd3, 1'b0, 1'b1);
    step();
    bus.i_Start = 1'b0;
  endtask

  task automatic ack_idle(string name);
    bus.i_Start = 1'b1;
    bus.i_Score = 5'd0;
    expect_ev(name, cyc + 1, 3'b000, 6'd3, 1'b0, 1'b0);
    step();
    bus.i_Start = 1'b0;
  endtask

  initial begin
    int t0;
    bus.i_Start = 1'b0;
    bus.i_Score = 5'd0;
`ifdef BOMB_PAUSE_EN
    bus.i_Pause = 1'b0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    snap("reset_state", 3'b000, 6'd3);
    step();

    // Start + timeout, with a stray start pulse mid-game
    start_game("start1", t0);
    expect_ev("to_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    expect_ev("to_tick2", t0 + 20, 3'b001, 6'd1, 1'b1, 1'b0);
    expect_ev("to_tick3", t0 + 30, 3'b001, 6'd0, 1'b1, 1'b0);
    expect_ev("to_fail",  t0 + 31, 3'b011, 6'd0, 1'b0, 1'b0);
    goto(t0 + 5);
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    goto(t0 + 45);
    snap("fail_frozen", 3'b011, 6'd0);
    ack_idle("fail_ack");
    step();

    // Clear mid-second
    start_game("start2", t0);
    expect_ev("cl_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    goto(t0 + 15);
    bus.i_Score = 5'd2;
    expect_ev("cl_clear", t0 + 16, 3'b010, 6'd2, 1'b0, 1'b0);
    goto(t0 + 24);
    snap("clear_frozen", 3'b010, 6'd2);
    ack_idle("clear_ack");
    step();

    // Clear arriving with the final tick
    start_game("start3", t0);
    expect_ev("sim_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    expect_ev("sim_tick2", t0 + 20, 3'b001, 6'd1, 1'b1, 1'b0);
    expect_ev("sim_tick3", t0 + 30, 3'b001, 6'd0, 1'b1, 1'b0);
    goto(t0 + 30);
    bus.i_Score = 5'd2;
    expect_ev("sim_clear", t0 + 31, 3'b010, 6'd0, 1'b0, 1'b0);
    goto(t0 + 35);
    ack_idle("sim_ack");
    step();

    // Reset mid-game, then a fresh start
    start_game("start4", t0);
    expect_ev("rst_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    goto(t0 + 17);
    rst = 1'b1;
    expect_ev("rst_idle", t0 + 18, 3'b000, 6'd3, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    start_game("start5", t0);
    expect_ev("post_rst_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    goto(t0 + 12);
    bus.i_Score = 5'd3;
    expect_ev("post_rst_clear", t0 + 13, 3'b010, 6'd2, 1'b0, 1'b0);
    goto(t0 + 15);
    ack_idle("post_rst_ack");
    step();

`ifdef BOMB_PAUSE_EN
    // Pause from cycle 5 to 25 shifts the first tick to cycle 30
    start_game("p_start", t0);
    goto(t0 + 5);
    bus.i_Pause = 1'b1;
    step();
    bus.i_Pause = 1'b0;
    goto(t0 + 12);
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    goto(t0 + 25);
    bus.i_Pause = 1'b1;
    step();
    bus.i_Pause = 1'b0;
    expect_ev("p_tick1", t0 + 30, 3'b001, 6'd2, 1'b1, 1'b0);
    goto(t0 + 33);
    bus.i_Score = 5'd2;
    expect_ev("p_clear", t0 + 34, 3'b010, 6'd2, 1'b0, 1'b0);
    goto(t0 + 36);
    ack_idle("p_ack");
    step();

    // Clear while paused; the flag must not survive into the next game
    start_game("p2_start", t0);
    goto(t0 + 3);
    bus.i_Pause = 1'b1;
    step();
    bus.i_Pause = 1'b0;
    goto(t0 + 8);
    bus.i_Score = 5'd2;
    expect_ev("p2_clear_paused", t0 + 9, 3'b010, 6'd3, 1'b0, 1'b0);
    goto(t0 + 11);
    ack_idle("p2_ack");
    step();
    start_game("p3_start", t0);
    expect_ev("p3_tick1", t0 + 10, 3'b001, 6'd2, 1'b1, 1'b0);
    goto(t0 + 11);
    bus.i_Score = 5'd2;
    expect_ev("p3_clear", t0 + 12, 3'b010, 6'd2, 1'b0, 1'b0);
    goto(t0 + 14);
    ack_idle("p3_ack");
`endif

    goto(cyc + 5);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
